dfe_multitap_eq: RTL and testbench

// Decision-feedback equaliser for the Rx simulation path, with a runtime-loadable tap set.

---
 rtl/dfe_multitap_eq.sv | 188 ++++++++++++++++++
 tb/tb_dfe_multitap_eq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dfe_multitap_eq.sv
// Decision-feedback equaliser with runtime-loadable post-cursor taps and THR.
// Each accepted sample is equalised, sliced (NRZ/PAM4) and fed back in one cycle.
module dfe_multitap_eq #(
    parameter int N_TAPS = 5,
    parameter int SIG_W  = 8,
    parameter int COEF_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              cfg_clear,
    input  logic              pam4,
    output logic              cfg_done,
    input  logic [SIG_W-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SIG_W-1:0]  out_eq,
    output logic [1:0]        out_sym,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  sat_count
);
    localparam int PROD_SUM_W = COEF_W + 2 + $clog2(N_TAPS);
    localparam int ACC_W = ((SIG_W > PROD_SUM_W) ? SIG_W : PROD_SUM_W) + 1;
    localparam logic signed [ACC_W-1:0] EQ_MAX = ACC_W'((1 << (SIG_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] EQ_MIN = ~EQ_MAX;

    typedef enum logic {S_CFG, S_RUN} state_t;

    state_t                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic [SIG_W-2:0]          thr_q, thr_d;
    logic signed [COEF_W-1:0]  coef_q [N_TAPS];
    logic signed [COEF_W-1:0]  coef_d [N_TAPS];
    logic signed [2:0]         hist_q [N_TAPS];
    logic signed [2:0]         hist_d [N_TAPS];
    logic [N_TAPS:0]           loaded_q, loaded_d;
    logic [SIG_W-1:0]          out_eq_q, out_eq_d;
    logic [1:0]                out_sym_q, out_sym_d;
    logic                      out_valid_q, out_valid_d;
    logic [CNT_W-1:0]          sat_cnt_q, sat_cnt_d;

    logic                      accept;
    logic signed [ACC_W-1:0]   isi, y, in_ext, thr_pos, thr_neg, c_ext, h_ext;
    logic [1:0]                sym;
    logic signed [2:0]         level;
    logic [SIG_W-1:0]          eq_sat;
    logic                      sat_hit;

    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign cfg_done  = (state_q == S_RUN);
    assign out_eq    = out_eq_q;
    assign out_sym   = out_sym_q;
    assign out_valid = out_valid_q;
    assign sat_count = sat_cnt_q;

    // Equalise and slice the current sample against the registered history.
    always_comb begin
        isi   = '0;
        c_ext = '0;
        h_ext = '0;
        for (int unsigned k = 0; k < N_TAPS; k++) begin
            c_ext = $signed({{(ACC_W-COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]});
            h_ext = $signed({{(ACC_W-3){hist_q[k][2]}}, hist_q[k]});
            isi   = isi + c_ext * h_ext;
        end
        in_ext  = $signed({{(ACC_W-SIG_W){in_data[SIG_W-1]}}, in_data});
        y       = in_ext - isi;
        thr_pos = $signed({{(ACC_W-SIG_W+1){1'b0}}, thr_q});
        thr_neg = -thr_pos;

        if (!mode_q) begin
            sym = (y >= 0) ? 2'b10 : 2'b01;
        end else if (y >= thr_pos) begin
            sym = 2'b11;
        end else if (y >= 0) begin
            sym = 2'b10;
        end else if (y >= thr_neg) begin
            sym = 2'b01;
        end else begin
            sym = 2'b00;
        end

        unique case (sym)
            2'b00:   level = -3'sd3;
            2'b01:   level = -3'sd1;
            2'b10:   level = 3'sd1;
            default: level = 3'sd3;
        endcase

        sat_hit = 1'b1;
        if (y > EQ_MAX) begin
            eq_sat = {1'b0, {(SIG_W-1){1'b1}}};
        end else if (y < EQ_MIN) begin
            eq_sat = {1'b1, {(SIG_W-1){1'b0}}};
        end else begin
            eq_sat  = y[SIG_W-1:0];
            sat_hit = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        thr_d       = thr_q;
        coef_d      = coef_q;
        hist_d      = hist_q;
        loaded_d    = loaded_q;
        out_eq_d    = out_eq_q;
        out_sym_d   = out_sym_q;
        out_valid_d = out_valid_q;
        sat_cnt_d   = sat_cnt_q;

        if (cfg_we) begin
            if (cfg_addr == 8'd0) begin
                thr_d = cfg_data[SIG_W-2:0];
            end
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                if (cfg_addr == 8'(k + 1)) begin
                    coef_d[k] = cfg_data;
                end
            end
            for (int unsigned a = 0; a <= N_TAPS; a++) begin
                if (cfg_addr == 8'(a)) begin
                    loaded_d[a] = 1'b1;
                end
            end
        end

        if (state_q == S_CFG && (&loaded_q)) begin
            state_d = S_RUN;
            mode_d  = pam4;
        end

        if (accept) begin
            hist_d[0] = level;
            for (int unsigned k = 1; k < N_TAPS; k++) begin
                hist_d[k] = hist_q[k-1];
            end
            out_eq_d    = eq_sat;
            out_sym_d   = sym;
            out_valid_d = 1'b1;
            if (sat_hit && (sat_cnt_q != '1)) begin
                sat_cnt_d = sat_cnt_q + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear overrides any accept or load completion in the same cycle; taps/THR survive.
        if (cfg_clear) begin
            state_d     = S_CFG;
            out_valid_d = 1'b0;
            loaded_d    = '0;
            hist_d      = '{default: '0};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_CFG;
            mode_q      <= 1'b0;
            thr_q       <= '0;
            coef_q      <= '{default: '0};
            hist_q      <= '{default: '0};
            loaded_q    <= '0;
            out_eq_q    <= '0;
            out_sym_q   <= '0;
            out_valid_q <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            thr_q       <= thr_d;
            coef_q      <= coef_d;
            hist_q      <= hist_d;
            loaded_q    <= loaded_d;
            out_eq_q    <= out_eq_d;
            out_sym_q   <= out_sym_d;
            out_valid_q <= out_valid_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end
endmodule

// File: tb/tb_dfe_multitap_eq.sv
// Directed self-checking bench for dfe_multitap_eq with hand-computed expectations.
module tb_dfe_multitap_eq;
    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_clear;
    logic        pam4;
    logic        cfg_done;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_eq;
    logic [1:0]  out_sym;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sat_count;

    int checks   = 0;
    int failures = 0;

    dfe_multitap_eq #(.N_TAPS(5), .SIG_W(8), .COEF_W(8), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_clear(cfg_clear), .pam4(pam4),
        .cfg_done(cfg_done), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_eq(out_eq), .out_sym(out_sym),
        .out_valid(out_valid), .out_ready(out_ready), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic load_taps(input logic [7:0] thr, input logic [7:0] c1, input logic p4);
        pam4 = p4;
        cfg_write(8'd0, thr);
        cfg_write(8'd1, c1);
        for (int a = 2; a <= 5; a++) cfg_write(8'(a), 8'd0);
        chk("cfg_done_after_last_write", {31'd0, cfg_done}, 32'd0);
        step();
        chk("cfg_done_rise", {31'd0, cfg_done}, 32'd1);
    endtask

    task automatic send(input string tag, input logic signed [7:0] d,
                        input logic signed [7:0] exp_eq, input logic [1:0] exp_sym);
        in_data = d; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_eq"}, $signed(out_eq), 32'(exp_eq));
        chk({tag, "_sym"}, {30'd0, out_sym}, {30'd0, exp_sym});
    endtask

    task automatic clear_pulse();
        cfg_clear = 1'b1;
        step();
        cfg_clear = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_clear = 1'b0;
        pam4 = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_eq", {24'd0, out_eq}, 32'd0);
        chk("rst_out_sym", {30'd0, out_sym}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
        rstn = 1'b1;
        step();

        // NRZ, c1=20: y = x - 20*h1
        load_taps(8'd40, 8'd20, 1'b0);
        send("nrz0", 8'sd50, 8'sd50, 2'b10);
        send("nrz1", -8'sd70, -8'sd90, 2'b01);
        send("nrz2", 8'sd30, 8'sd50, 2'b10);

        // Backpressure: previous output must hold, history untouched
        in_data = 8'sd10; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("stall_in_ready0", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_eq", $signed(out_eq), 32'd50);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        send("after_stall", 8'sd10, -8'sd10, 2'b01);

        // c1 write coincident with accepted sample: old c1 applies to it
        cfg_we = 1'b1; cfg_addr = 8'd1; cfg_data = 8'd30;
        in_data = 8'sd0; in_valid = 1'b1; out_ready = 1'b1;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("wr_same_cycle_eq", $signed(out_eq), 32'd20);
        chk("wr_same_cycle_sym", {30'd0, out_sym}, 32'b10);
        send("wr_next", 8'sd0, -8'sd30, 2'b01);

        // Saturation
        chk("sat_zero", {16'd0, sat_count}, 32'd0);
        cfg_write(8'd1, 8'd100);
        send("sat_pos", 8'sd100, 8'sd127, 2'b10);
        chk("sat_cnt1", {16'd0, sat_count}, 32'd1);
        send("sat_neg", -8'sd100, -8'sd128, 2'b01);
        chk("sat_cnt2", {16'd0, sat_count}, 32'd2);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65533; i++) begin
            in_data = (i % 2 == 0) ? 8'sd100 : -8'sd100;
            step();
        end
        chk("sat_cnt_max", {16'd0, sat_count}, 32'hFFFF);
        for (int i = 0; i < 2; i++) begin
            in_data = (i % 2 == 0) ? -8'sd100 : 8'sd100;
            step();
        end
        in_valid = 1'b0;
        chk("sat_cnt_hold", {16'd0, sat_count}, 32'hFFFF);
        chk("sat_last_eq", $signed(out_eq), 32'd127);
        step();
        chk("idle_valid_drop", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset in the middle of RUN
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_out_eq", {24'd0, out_eq}, 32'd0);
        chk("mid_rst_out_sym", {30'd0, out_sym}, 32'd0);
        chk("mid_rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        chk("mid_rst_sat", {16'd0, sat_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rstn = 1'b1;
        step();
        load_taps(8'd40, 8'd100, 1'b0);
        send("post_rst", 8'sd50, 8'sd50, 2'b10);

        // cfg_clear: back to CFG, samples refused, history zeroed
        clear_pulse();
        chk("clr_cfg_done", {31'd0, cfg_done}, 32'd0);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        in_data = -8'sd50; in_valid = 1'b1;
        #1;
        chk("cfg_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("cfg_no_accept", {31'd0, out_valid}, 32'd0);
        load_taps(8'd40, 8'd100, 1'b0);
        send("hist_cleared", 8'sd5, 8'sd5, 2'b10);

        // PAM4, THR=40, zero taps
        clear_pulse();
        load_taps(8'd40, 8'd0, 1'b1);
        send("pam0", 8'sd60, 8'sd60, 2'b11);
        send("pam1", 8'sd20, 8'sd20, 2'b10);
        send("pam2", -8'sd20, -8'sd20, 2'b01);
        send("pam3", -8'sd60, -8'sd60, 2'b00);
        send("pam4_thr", 8'sd40, 8'sd40, 2'b11);
        send("pam5_zero", 8'sd0, 8'sd0, 2'b10);
        send("pam6_nthr", -8'sd40, -8'sd40, 2'b01);
        send("pam7_below", -8'sd41, -8'sd41, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
